// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Generates sequential PCs and keeps at most one read outstanding to
// instruction memory. Returned words are queued with their PC in a small
// prefetch FIFO and handed to the consumer over a valid/ready handshake.
// A redirect flushes the FIFO and any in-flight read, then fetching
// restarts from the new PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Fetch addresses are always word aligned, including the reset PC.
    localparam logic [31:0]      RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [CNT_W:0]   DEPTH_V    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // FETCH: nothing outstanding. WAIT: read outstanding, data kept.
    // FLUSH: read outstanding but made stale by a redirect, data dropped.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_r;
    logic [31:0]       fetch_pc_r;
    logic [31:0]       req_pc_r;
    logic [31:0]       data_mem_r [FIFO_DEPTH];
    logic [31:0]       pc_mem_r   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              fifo_valid_s;
    logic              pop_s;
    logic              push_s;
    logic [CNT_W:0]    occupancy_s;
    logic              space_s;
    logic              slot_s;
    logic              issue_s;
    logic [31:0]       redirect_target_s;

    // Handshake, FIFO space and request-issue decisions for this cycle.
    always_comb begin
        fifo_valid_s      = (count_r != '0);
        pop_s             = fifo_valid_s && instr_ready;
        // Only data for a live (non-flushed) request is kept, and a redirect
        // in the same cycle kills it as well.
        push_s            = (state_r == ST_WAIT) && imem_rvalid && !redirect_valid;
        // A same-cycle pop is deliberately not credited as free space.
        occupancy_s       = {1'b0, count_r} + {{CNT_W{1'b0}}, push_s};
        space_s           = (occupancy_s < DEPTH_V);
        redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
        case (state_r)
            ST_FETCH: slot_s = 1'b1;
            // The outstanding read completes this cycle, freeing the slot.
            ST_WAIT,
            ST_FLUSH: slot_s = imem_rvalid;
            default:  slot_s = 1'b0;
        endcase
        // No request is driven while reset is held.
        issue_s = reset_n && !redirect_valid && space_s && slot_s;
    end

    // Drive the memory request and the FIFO head onto the outputs.
    always_comb begin
        imem_req    = issue_s;
        imem_addr   = fetch_pc_r;
        instr_valid = fifo_valid_s;
        instr       = fifo_valid_s ? data_mem_r[rd_ptr_r] : 32'h0000_0000;
        instr_pc    = fifo_valid_s ? pc_mem_r[rd_ptr_r]   : 32'h0000_0000;
    end

    // Fetch FSM with fetch PC and the PC of the outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= RESET_PC_A;
            req_pc_r   <= RESET_PC_A;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_target_s;
            case (state_r)
                // An in-flight read becomes stale unless it returns now.
                ST_WAIT,
                ST_FLUSH: state_r <= imem_rvalid ? ST_FETCH : ST_FLUSH;
                default:  state_r <= ST_FETCH;
            endcase
        end else if (issue_s) begin
            state_r    <= ST_WAIT;
            fetch_pc_r <= fetch_pc_r + 32'd4;
            req_pc_r   <= fetch_pc_r;
        end else if ((state_r != ST_FETCH) && imem_rvalid) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_r;
        end
    end

    // Prefetch FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]   <= 32'h0000_0000;
            end
        end else if (redirect_valid) begin
            // Flush: everything queued belongs to the abandoned path.
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= imem_rdata;
                pc_mem_r[wr_ptr_r]   <= req_pc_r;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
